// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM driver and its timing helpers.
package pwm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DEAD = 2'd2
   } state_t;

   localparam logic [7:0] PWM_MAX        = 8'd255;
   localparam logic [7:0] PWM_LAST_COUNT = 8'd254;

   // Move cur toward tgt by at most step, landing exactly on tgt when close enough.
   function automatic logic [7:0] slew_toward(input logic [7:0] cur, input logic [7:0] tgt,
                                              input int step);
      int diff;
      diff = int'(tgt) - int'(cur);
      if (diff > step)       return 8'(int'(cur) + step);
      else if (diff < -step) return 8'(int'(cur) - step);
      else                   return tgt;
   endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Free-running divide-by-PRESCALE counter; tick marks the last clock of each step.
module pwm_prescaler import pwm_pkg::*; #(
   parameter int PRESCALE = 4
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clear,
   output logic tick
);

   localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [W-1:0] cnt;

   assign tick = !clear && (cnt == W'(PRESCALE - 1));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)            cnt <= '0;
      else if (clear || tick)  cnt <= '0;
      else                     cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/pwm_driver.sv
// Motor PWM generator: applies ratio requests at period boundaries, with dead time on
// direction reversal. Define PWM_SLEW_EN to ramp the ratio by SLEW_STEP per period.
module pwm_driver import pwm_pkg::*; #(
   parameter int PRESCALE         = 4,
   parameter int DEADTIME_PERIODS = 2,
   parameter int SLEW_STEP        = 8
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       pwm_enable,
   input  logic       pwm_update,
   input  logic [7:0] pwm_ratio,
   input  logic       pwm_direction,
   output logic       pwm_done,
   output logic       pwm_out,
   output logic       dir_out,
   output logic       busy
);

`ifdef PWM_SLEW_EN
   localparam bit SLEW_ON = 1'b1;
`else
   localparam bit SLEW_ON = 1'b0;
`endif
   // Without slewing, a step limit of full scale lands on the target in one move.
   localparam int STEP_LIMIT = SLEW_ON ? SLEW_STEP : int'(PWM_MAX);

   state_t     state;
   logic [7:0] count, applied, pend_ratio, dead_cnt;
   logic [7:0] step_ratio, exit_ratio;
   logic       pend_dir, pend_flag;
   logic       tick, boundary, presc_clear;

   assign presc_clear = !pwm_enable || (state == IDLE);

   pwm_prescaler #(.PRESCALE(PRESCALE)) u_presc (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (presc_clear),
      .tick    (tick)
   );

   assign boundary   = tick && (count == PWM_LAST_COUNT);
   assign step_ratio = slew_toward(applied, pend_ratio, STEP_LIMIT);
   assign exit_ratio = SLEW_ON ? 8'd0 : pend_ratio;
   assign busy       = pend_flag || (state == DEAD);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         count      <= '0;
         applied    <= '0;
         pend_ratio <= '0;
         pend_dir   <= 1'b0;
         pend_flag  <= 1'b0;
         dead_cnt   <= '0;
         pwm_done   <= 1'b0;
         pwm_out    <= 1'b0;
         dir_out    <= 1'b0;
      end else begin
         pwm_done <= 1'b0;
         pwm_out  <= pwm_enable && (state == RUN) && (count < applied);

         if (presc_clear)  count <= '0;
         else if (tick)    count <= (count == PWM_LAST_COUNT) ? 8'd0 : count + 8'd1;

         if (!pwm_enable) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (!pend_flag) begin
                     state <= RUN;
                  end else if (pend_dir == dir_out) begin
                     state   <= RUN;
                     applied <= step_ratio;
                     if (step_ratio == pend_ratio) begin
                        pend_flag <= 1'b0;
                        pwm_done  <= 1'b1;
                     end
                  end else begin
                     state    <= DEAD;
                     dead_cnt <= 8'(DEADTIME_PERIODS);
                  end
               end
               RUN: begin
                  if (boundary && pend_flag) begin
                     if (pend_dir == dir_out) begin
                        applied <= step_ratio;
                        if (step_ratio == pend_ratio) begin
                           pend_flag <= 1'b0;
                           pwm_done  <= 1'b1;
                        end
                     end else begin
                        state    <= DEAD;
                        dead_cnt <= 8'(DEADTIME_PERIODS);
                     end
                  end
               end
               DEAD: begin
                  // A request back to the current direction cancels the remaining dead time.
                  if (boundary) begin
                     if ((pend_dir == dir_out) || (dead_cnt <= 8'd1)) begin
                        state    <= RUN;
                        dir_out  <= pend_dir;
                        applied  <= exit_ratio;
                        dead_cnt <= '0;
                        if (exit_ratio == pend_ratio) begin
                           pend_flag <= 1'b0;
                           pwm_done  <= 1'b1;
                        end
                     end else begin
                        dead_cnt <= dead_cnt - 8'd1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end

         // Capture last so a request in a boundary cycle survives the clear above.
         if (pwm_update) begin
            pend_ratio <= pwm_ratio;
            pend_dir   <= pwm_direction;
            pend_flag  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pwm_driver.sv
// Directed bench for pwm_driver at PRESCALE=4, DEADTIME_PERIODS=2 (period = 1020 clocks).
module tb_pwm_driver;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       pwm_enable = 1'b0;
   logic       pwm_update = 1'b0;
   logic [7:0] pwm_ratio = 8'd0;
   logic       pwm_direction = 1'b0;
   logic       pwm_done, pwm_out, dir_out, busy;

   int checks = 0;
   int failures = 0;

   pwm_driver dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .pwm_enable    (pwm_enable),
      .pwm_update    (pwm_update),
      .pwm_ratio     (pwm_ratio),
      .pwm_direction (pwm_direction),
      .pwm_done      (pwm_done),
      .pwm_out       (pwm_out),
      .dir_out       (dir_out),
      .busy          (busy)
   );

   always #5 clock = ~clock;

   task automatic test_reset;
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      checks++; if (pwm_out !== 1'b0)  begin failures++; $display("FAIL reset_pwm_out got=%0b exp=0", pwm_out); end
      checks++; if (pwm_done !== 1'b0) begin failures++; $display("FAIL reset_pwm_done got=%0b exp=0", pwm_done); end
      checks++; if (dir_out !== 1'b0)  begin failures++; $display("FAIL reset_dir_out got=%0b exp=0", dir_out); end
      checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
      reset_n = 1'b1;
      @(negedge clock);
   endtask

   // Enable, then request 128/dir0 at cycle 10; first boundary is cycle 1019.
   task automatic test_basic;
      int dones = 0, highs = 0, done_at = -1;
      pwm_enable = 1'b1;
      pwm_ratio = 8'd128; pwm_direction = 1'b0;
      for (int k = 0; k <= 2040; k++) begin
         @(negedge clock);
         if (pwm_done === 1'b1) begin dones++; if (done_at < 0) done_at = k; end
         if (k >= 1021) highs += int'(pwm_out);
         if (k == 500) begin
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_pending got=%0b exp=1", busy); end
         end
         if (k == 1020) begin
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%0b exp=0", busy); end
         end
         if (k == 1021) begin
            checks++; if (pwm_out !== 1'b1) begin failures++; $display("FAIL basic_first_high got=%0b exp=1", pwm_out); end
         end
         if (k == 1533) begin
            checks++; if (pwm_out !== 1'b0) begin failures++; $display("FAIL basic_fall got=%0b exp=0", pwm_out); end
         end
         pwm_update = (k == 10);
      end
      checks++; if (done_at !== 1020) begin failures++; $display("FAIL basic_done_cycle got=%0d exp=1020", done_at); end
      checks++; if (dones !== 1)      begin failures++; $display("FAIL basic_done_count got=%0d exp=1", dones); end
      checks++; if (highs !== 512)    begin failures++; $display("FAIL basic_high_clocks got=%0d exp=512", highs); end
      checks++; if (dir_out !== 1'b0) begin failures++; $display("FAIL basic_dir got=%0b exp=0", dir_out); end
   endtask

   // Ratio 0 then 255: each applied at its own boundary, one done each.
   task automatic test_extremes;
      int dones = 0, highs0 = 0, highs255 = 0;
      for (int j = 1; j <= 3060; j++) begin
         @(negedge clock);
         if (pwm_done === 1'b1) dones++;
         if (j >= 1021 && j <= 2040) highs0 += int'(pwm_out);
         if (j >= 2041) highs255 += int'(pwm_out);
         pwm_update = (j == 10) || (j == 1030);
         pwm_ratio  = (j < 1030) ? 8'd0 : 8'd255;
      end
      checks++; if (highs0 !== 0)      begin failures++; $display("FAIL ratio0_high_clocks got=%0d exp=0", highs0); end
      checks++; if (highs255 !== 1020) begin failures++; $display("FAIL ratio255_high_clocks got=%0d exp=1020", highs255); end
      checks++; if (dones !== 2)       begin failures++; $display("FAIL extremes_done_count got=%0d exp=2", dones); end
   endtask

   // Two updates merged in one period; then an update landing exactly in a boundary cycle.
   task automatic test_back_to_back;
      int dones = 0, highs200 = 0, highs80 = 0;
      for (int j = 1; j <= 4080; j++) begin
         @(negedge clock);
         if (pwm_done === 1'b1) dones++;
         if (j >= 1021 && j <= 2040) highs200 += int'(pwm_out);
         if (j >= 3061) highs80 += int'(pwm_out);
         if (j == 1020) begin
            checks++; if (pwm_done !== 1'b1) begin failures++; $display("FAIL merge_done got=%0b exp=1", pwm_done); end
         end
         if (j == 2040) begin
            checks++; if (pwm_done !== 1'b0) begin failures++; $display("FAIL edge_update_early_done got=%0b exp=0", pwm_done); end
            checks++; if (busy !== 1'b1)     begin failures++; $display("FAIL edge_update_busy got=%0b exp=1", busy); end
         end
         if (j == 3060) begin
            checks++; if (pwm_done !== 1'b1) begin failures++; $display("FAIL edge_update_done got=%0b exp=1", pwm_done); end
         end
         pwm_update = (j == 100) || (j == 300) || (j == 2039);
         pwm_ratio  = (j < 300) ? 8'd50 : ((j < 2039) ? 8'd200 : 8'd80);
      end
      checks++; if (highs200 !== 800) begin failures++; $display("FAIL merge_high_clocks got=%0d exp=800", highs200); end
      checks++; if (highs80 !== 320)  begin failures++; $display("FAIL edge_high_clocks got=%0d exp=320", highs80); end
      checks++; if (dones !== 2)      begin failures++; $display("FAIL b2b_done_count got=%0d exp=2", dones); end
   endtask

   // Drop enable at cycle 50, restore at 70; RUN restarts at cycle 71 with count 0.
   task automatic test_enable_drop;
      int dones = 0, highs = 0, idle_highs = 0;
      for (int j = 1; j <= 1091; j++) begin
         @(negedge clock);
         if (pwm_done === 1'b1) dones++;
         if (j >= 51 && j <= 71) idle_highs += int'(pwm_out);
         if (j >= 72) highs += int'(pwm_out);
         if (j == 50) begin
            checks++; if (pwm_out !== 1'b1) begin failures++; $display("FAIL drop_before got=%0b exp=1", pwm_out); end
         end
         if (j == 51) begin
            checks++; if (pwm_out !== 1'b0) begin failures++; $display("FAIL drop_next_cycle got=%0b exp=0", pwm_out); end
         end
         if (j == 72) begin
            checks++; if (pwm_out !== 1'b1) begin failures++; $display("FAIL resume_first got=%0b exp=1", pwm_out); end
         end
         if (j == 392) begin
            checks++; if (pwm_out !== 1'b0) begin failures++; $display("FAIL resume_fall got=%0b exp=0", pwm_out); end
         end
         if (j == 50) pwm_enable = 1'b0;
         if (j == 70) pwm_enable = 1'b1;
      end
      checks++; if (idle_highs !== 0) begin failures++; $display("FAIL drop_idle_high got=%0d exp=0", idle_highs); end
      checks++; if (highs !== 320)    begin failures++; $display("FAIL resume_high_clocks got=%0d exp=320", highs); end
      checks++; if (dones !== 0)      begin failures++; $display("FAIL drop_done_count got=%0d exp=0", dones); end
   endtask

   // 100/dir0, then 60/dir1: dead time spans cycles 2040..4079, exit done at 4080.
   task automatic test_dead_time;
      int dones = 0, dead_highs = 0, highs = 0;
      for (int j = 1; j <= 5100; j++) begin
         @(negedge clock);
         if (pwm_done === 1'b1) dones++;
         if (j >= 2040 && j <= 4080) dead_highs += int'(pwm_out);
         if (j >= 4081) highs += int'(pwm_out);
         if (j == 4079) begin
            checks++; if (dir_out !== 1'b0) begin failures++; $display("FAIL dead_dir_hold got=%0b exp=0", dir_out); end
            checks++; if (busy !== 1'b1)    begin failures++; $display("FAIL dead_busy got=%0b exp=1", busy); end
         end
         if (j == 4080) begin
            checks++; if (dir_out !== 1'b1)  begin failures++; $display("FAIL dead_dir_flip got=%0b exp=1", dir_out); end
            checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL dead_busy_clear got=%0b exp=0", busy); end
            checks++; if (pwm_done !== 1'b1) begin failures++; $display("FAIL dead_done got=%0b exp=1", pwm_done); end
         end
         if (j == 4081) begin
            checks++; if (pwm_out !== 1'b1) begin failures++; $display("FAIL dead_resume got=%0b exp=1", pwm_out); end
         end
         pwm_update    = (j == 10) || (j == 1220);
         pwm_ratio     = (j < 1220) ? 8'd100 : 8'd60;
         pwm_direction = (j >= 1220);
      end
      checks++; if (dead_highs !== 0) begin failures++; $display("FAIL dead_high_clocks got=%0d exp=0", dead_highs); end
      checks++; if (highs !== 240)    begin failures++; $display("FAIL dead_after_high got=%0d exp=240", highs); end
      checks++; if (dones !== 2)      begin failures++; $display("FAIL dead_done_count got=%0d exp=2", dones); end
   endtask

   // Reset between clock edges with output high, dir 1 and a request pending.
   task automatic test_async_reset;
      for (int j = 1; j <= 22; j++) begin
         @(negedge clock);
         pwm_update = (j == 20);
         pwm_ratio  = 8'd10;
      end
      checks++; if (pwm_out !== 1'b1) begin failures++; $display("FAIL pre_reset_out got=%0b exp=1", pwm_out); end
      checks++; if (busy !== 1'b1)    begin failures++; $display("FAIL pre_reset_busy got=%0b exp=1", busy); end
      #2 reset_n = 1'b0;
      #1;
      checks++; if (pwm_out !== 1'b0)  begin failures++; $display("FAIL async_pwm_out got=%0b exp=0", pwm_out); end
      checks++; if (dir_out !== 1'b0)  begin failures++; $display("FAIL async_dir_out got=%0b exp=0", dir_out); end
      checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL async_busy got=%0b exp=0", busy); end
      checks++; if (pwm_done !== 1'b0) begin failures++; $display("FAIL async_done got=%0b exp=0", pwm_done); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_extremes();
      test_back_to_back();
      test_enable_drop();
      test_dead_time();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
